mul_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations for the multicycle core.
- Sits beside the ALU in the datapath, sharing operands a/b (register-file outputs after the A/B flops).
- Its result feeds the ALU-out register path.
- The controller holds the multicycle FSM in a wait state while busy is high and resumes on done.

---
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One operand bit per cycle for XLEN cycles, then one sign-fix cycle, so the
// latency is the same for every op and every operand value.
//
// state | meaning
// IDLE  | waiting for start; result holds the last value
// CALC  | XLEN shift-add (multiply) or restoring-divide steps
// FIX   | sign correction, result select and register
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    // latched operation context
    logic [2:0]        op;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [CW-1:0]     count;

    // multiply accumulator: high half partial sum, low half remaining multiplier bits
    logic [2*XLEN-1:0] acc;
    // divide: remainder fits XLEN bits between steps; quo starts as the dividend
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;

    // acceptance-time operand decode
    logic              signed_a_in;
    logic              signed_b_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;

    // per-step datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     div_shift;
    logic              div_ok;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;

    // sign fix
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_next;

    assign busy = (state != IDLE);

    // decode signedness of the incoming op and take operand magnitudes
    always_comb begin
        signed_a_in = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV)  || (funct3 == OP_REM);
        signed_b_in = (funct3 == OP_MULH) || (funct3 == OP_DIV) ||
                      (funct3 == OP_REM);
        neg_a_in    = signed_a_in & a[XLEN-1];
        neg_b_in    = signed_b_in & b[XLEN-1];
        mag_a_in    = neg_a_in ? -a : a;
        mag_b_in    = neg_b_in ? -b : b;
    end

    // one shift-add step and one restoring-divide step
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : {XLEN{1'b0}})};
        acc_step  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {rem, quo[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, mag_b});
        // when the subtract succeeds the true difference is below mag_b, so XLEN bits suffice
        div_diff  = div_shift[XLEN-1:0] - mag_b;
        rem_step  = div_ok ? div_diff : div_shift[XLEN-1:0];
        quo_step  = {quo[XLEN-2:0], div_ok};
    end

    // sign correction and result select; divide by zero keeps an all-ones quotient
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = ((neg_a ^ neg_b) && (mag_b != '0)) ? -quo : quo;
        rem_fix  = neg_a ? -rem : rem;
        case (op)
            OP_MUL:                     result_next = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   result_next = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            result_next = quo_fix;
            default:                    result_next = rem_fix;
        endcase
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // operand latch, iteration registers, result and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            count  <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        neg_a <= neg_a_in;
                        neg_b <= neg_b_in;
                        mag_a <= mag_a_in;
                        mag_b <= mag_b_in;
                        count <= CW'(XLEN);
                        acc   <= {{XLEN{1'b0}}, mag_b_in};
                        rem   <= '0;
                        quo   <= mag_a_in;
                    end
                end
                CALC: begin
                    count <= count - CW'(1);
                    if (op[2]) begin
                        rem <= rem_step;
                        quo <= quo_step;
                    end else begin
                        acc <= acc_step;
                    end
                end
                FIX: begin
                    result <= result_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at XLEN=32 and XLEN=8.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;

    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic        start_8;
    logic [2:0]  funct3_8;
    logic [7:0]  a_8;
    logic [7:0]  b_8;
    logic        busy_8;
    logic        done_8;
    logic [7:0]  result_8;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    mul_div_unit #(.XLEN(8)) dut_8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start_8),
        .funct3 (funct3_8),
        .a      (a_8),
        .b      (b_8),
        .busy   (busy_8),
        .done   (done_8),
        .result (result_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic start32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        funct3 = f;
        a      = x;
        b      = y;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // walks edges 1..33, busy must be high and done low throughout,
    // then checks done/busy/result after edge 33; glitch_k>0 pulses start with new operands
    task automatic finish32(input string tag, input logic [31:0] exp, input int glitch_k);
        int bad;
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k == glitch_k) begin
                start  = 1'b1;
                a      = ~a;
                b      = b + 32'd5;
                funct3 = DIV;
            end
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_busy_window"}, bad, 0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, result, exp);
    endtask

    task automatic gap32();
        @(negedge clk);
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
        start32(f, x, y);
        finish32(tag, exp, 0);
        gap32();
    endtask

    task automatic op8(input string tag, input logic [2:0] f, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] exp);
        int bad;
        funct3_8 = f;
        a_8      = x;
        b_8      = y;
        start_8  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_8  = 1'b0;
        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            if (busy_8 !== 1'b1 || done_8 !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, "_busy_window"}, bad, 0);
        check({tag, "_done"}, {31'd0, done_8}, 32'd1);
        check({tag, "_result"}, {24'd0, result_8}, {24'd0, exp});
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, done_8}, 32'd0);
    endtask

    initial begin
        logic [31:0] old_result;
        int bad;

        rst      = 1'b1;
        start    = 1'b0;
        funct3   = '0;
        a        = '0;
        b        = '0;
        start_8  = 1'b0;
        funct3_8 = '0;
        a_8      = '0;
        b_8      = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, busy},   32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        check("reset_result", result,          32'd0);
        rst = 1'b0;
        @(negedge clk);

        op32("mul_7_m3",        MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        op32("mulh_min_min",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        op32("mulhu_ones",      MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op32("mulhsu_ones",     MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op32("mul_6_7",         MUL,    32'd6,        32'd7,         32'd42);
        op32("div_m7_2",        DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        op32("rem_m7_2",        REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        op32("divu_100_7",      DIVU,   32'd100,      32'd7,         32'd14);
        op32("remu_100_7",      REMU,   32'd100,      32'd7,         32'd2);
        op32("divu_by_zero",    DIVU,   32'h1234,     32'd0,         32'hFFFF_FFFF);
        op32("rem_by_zero",     REM,    32'h1234,     32'd0,         32'h1234);
        op32("div_neg_by_zero", DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
        op32("rem_neg_by_zero", REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
        op32("div_overflow",    DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        op32("rem_overflow",    REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        op32("div_7_m2",        DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD);

        // start pulsed while busy with different operands and funct3: ignored
        start32(MUL, 32'd9, 32'd11);
        finish32("start_while_busy", 32'd99, 10);
        gap32();

        // start on the done cycle is accepted
        start32(MUL, 32'd7, 32'hFFFF_FFFD);
        finish32("chain_first", 32'hFFFF_FFEB, 0);
        old_result = result;
        start32(DIVU, 32'd100, 32'd7);
        check("chain_result_held", result, old_result);
        finish32("chain_second", 32'd14, 0);
        gap32();

        // asynchronous reset in the middle of a divide
        start32(DIV, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop_rst_busy",   {31'd0, busy}, 32'd0);
        check("midop_rst_done",   {31'd0, done}, 32'd0);
        check("midop_rst_result", result,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("no_done_after_rst", bad, 0);
        op32("after_rst_remu", REMU, 32'd100, 32'd7, 32'd2);

        op8("x8_div_m7_2",  DIV,   8'hF9, 8'h02, 8'hFD);
        op8("x8_rem_m7_2",  REM,   8'hF9, 8'h02, 8'hFF);
        op8("x8_mul_7_m3",  MUL,   8'h07, 8'hFD, 8'hEB);
        op8("x8_mulhu_ff",  MULHU, 8'hFF, 8'hFF, 8'hFE);
        op8("x8_divu_100_7", DIVU, 8'd100, 8'd7, 8'd14);
        op8("x8_div_ovf",   DIV,   8'h80, 8'hFF, 8'h80);
        op8("x8_divu_zero", DIVU,  8'h34, 8'h00, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
